// File: rtl/pooling_pkg.sv
// Shared types and address helpers for the 2x2 max-pooling window reader.
package pooling_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Top-left element address of window w in a row-major tile of side tile_dim.
  function automatic int unsigned win_base(input int unsigned w, input int unsigned tile_dim);
    int unsigned half;
    half = tile_dim / 32'd2;
    return 32'd2 * (w / half) * tile_dim + 32'd2 * (w % half);
  endfunction

  // Offset of beat 0..3 inside a window: b, b+1, b+T, b+T+1.
  function automatic int unsigned beat_offset(input int unsigned beat, input int unsigned tile_dim);
    return (beat / 32'd2) * tile_dim + (beat % 32'd2);
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational two's-complement maximum of two elements.
module pool_max2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] max_o
);

  assign max_o = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;

endmodule

// File: rtl/pool_window_reader.sv
// Walks a square tile in 2x2 windows, reads each window from a 1-cycle-latency
// register file and hands out the signed maximum over a valid/ready port.
module pool_window_reader
  import pooling_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TILE_DIM   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [ADDR_WIDTH-3:0] res_idx
);

  localparam int IDX_W   = ADDR_WIDTH - 2;
  localparam int NUM_WIN = (TILE_DIM / 2) * (TILE_DIM / 2);

  state_t                  state_q, state_d;
  logic [1:0]              beat_q, beat_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   max_s;
  logic                    last_win_s;

  pool_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_max (
    .a_i   (acc_q),
    .b_i   (rd_data),
    .max_o (max_s)
  );

  assign last_win_s = (win_q == IDX_W'(NUM_WIN - 1));
  assign res_data   = acc_q;
  assign res_idx    = win_q;

  // State, beat, window and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      win_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic; rd_data lags the address by one cycle, so the
  // accumulator runs one beat behind the address sequence.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    win_d   = win_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          beat_d  = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd1) begin
          acc_d = rd_data;
        end else if (beat_q != 2'd0) begin
          acc_d = max_s;
        end else begin
          acc_d = acc_q;
        end
        if (beat_q == 2'd3) begin
          state_d = DRAIN;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        acc_d   = max_s;
        state_d = OUT;
      end
      OUT: begin
        if (res_ready) begin
          beat_d = 2'd0;
          if (last_win_s) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            win_d   = win_q + IDX_W'(1);
          end
        end else begin
          state_d = OUT;
        end
      end
      DONE: begin
        win_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    res_valid = 1'b0;
    rd_addr   = '0;
    case (state_q)
      IDLE:  busy = 1'b0;
      READ:  rd_addr = ADDR_WIDTH'(win_base(32'(win_q), 32'(TILE_DIM))
                                  + beat_offset(32'(beat_q), 32'(TILE_DIM)));
      DRAIN: rd_addr = '0;
      OUT:   res_valid = 1'b1;
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pool_window_reader.sv
// Randomized self-checking bench for pool_window_reader with a behavioural
// register file and a window-level reference model.
module tb_pool_window_reader;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int TILE = 4;
  localparam int NWIN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, res_valid, res_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] res_data;
  logic [AW-3:0] res_idx;

  logic [DW-1:0] mem [16];
  int            n_checks = 0;
  int            n_errors = 0;
  int            done_cnt = 0;
  int            hold_w [NWIN];

  pool_window_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TILE_DIM(TILE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle registered read.
  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int w, input int k);
    return 2 * (w / 2) * TILE + 2 * (w % 2) + (k / 2) * TILE + (k % 2);
  endfunction

  function automatic logic [DW-1:0] exp_max(input int w);
    int best, v;
    best = int'($signed(mem[exp_addr(w, 0)]));
    for (int k = 1; k < 4; k++) begin
      v = int'($signed(mem[exp_addr(w, k)]));
      if (v > best) best = v;
    end
    return DW'(best);
  endfunction

  // Runs one full tile; inputs change on the falling edge, outputs sampled there.
  task automatic run_tile(input int glitch_win);
    int d0;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int w = 0; w < NWIN; w++) begin
      for (int k = 0; k < 4; k++) begin
        check("rd_addr", 32'(rd_addr), 32'(exp_addr(w, k)));
        check("read_valid", 32'(res_valid), 32'd0);
        check("read_busy", 32'(busy), 32'd1);
        start = (w == glitch_win && k == 1) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
      start = 1'b0;
      check("drain_valid", 32'(res_valid), 32'd0);
      check("drain_addr", 32'(rd_addr), 32'd0);
      res_ready = (hold_w[w] > 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      for (int h = 0; h < hold_w[w]; h++) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data", 32'(res_data), 32'(exp_max(w)));
        check("hold_idx", 32'(res_idx), 32'(w));
        check("hold_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
      end
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_data", 32'(res_data), 32'(exp_max(w)));
      check("res_idx", 32'(res_idx), 32'(w));
      res_ready = 1'b1;
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("done_low", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_idx", 32'(res_idx), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_addr", 32'(rd_addr), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_data"}, 32'(res_data), 32'd0);
    check({tag, "_idx"}, 32'(res_idx), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    for (int w = 0; w < NWIN; w++) hold_w[w] = 0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // Ramp data: results 5, 7, 13, 15.
    check("ramp_ref0", 32'(exp_max(0)), 32'd5);
    run_tile(-1);

    // Mixed-sign window 0, consumer stall of 10 cycles on window 1.
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    mem[0] = 16'h8000; mem[1] = 16'hFFFF; mem[4] = 16'h8001; mem[5] = 16'hFFFE;
    hold_w[0] = 0; hold_w[1] = 10; hold_w[2] = 1; hold_w[3] = 2;
    check("neg_ref0", 32'(exp_max(0)), 32'hFFFF);
    run_tile(-1);

    // Start pulsed during READ of window 2 is ignored.
    for (int w = 0; w < NWIN; w++) hold_w[w] = 0;
    run_tile(2);

    // Reset in DRAIN of window 1 abandons the tile.
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; res_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_addr", 32'(rd_addr), 32'd0);
    check("pre_rst_valid", 32'(res_valid), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_tile(-1);

    // Random data and random stalls.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
      if (t == 2) for (int i = 0; i < 16; i++) mem[i] = 16'h1234;
      for (int w = 0; w < NWIN; w++) hold_w[w] = int'($urandom_range(0, 4));
      run_tile(int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
